// File: rtl/rc_envelope_vcontrol_pkg.sv
// Shared definitions for the discrete RC sound stages: envelope states,
// full-scale voltage and the Q16 RC coefficient helper.
package discrete_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHARGE    = 2'd1,
        HOLD      = 2'd2,
        DISCHARGE = 2'd3
    } env_state_t;

    localparam logic [15:0] VCC_16 = 16'hFFFF;

    // K = 2^51 / (R * C * 2^35 * FS), clamped to [1, 65535]
    function automatic logic [15:0] rc_coef_q16(
        input longint unsigned r,
        input longint unsigned c_35,
        input longint unsigned fs
    );
        longint unsigned den;
        longint unsigned k;
        den = r * c_35 * fs;
        if (den == 0) begin
            return 16'hFFFF;
        end
        k = (64'd1 << 51) / den;
        if (k < 1) begin
            return 16'd1;
        end
        if (k > 65535) begin
            return 16'hFFFF;
        end
        return k[15:0];
    endfunction

endpackage

// File: rtl/rc_envelope_vcontrol_if.sv
// Sample strobe, trigger and control-voltage outputs of the envelope generator.
interface rc_envelope_vcontrol_if;
    logic        audio_clk_en;
    logic        trigger;
    logic [15:0] v_out;
    logic        busy;

    modport master (output audio_clk_en, output trigger, input v_out, input busy);
    modport slave  (input audio_clk_en, input trigger, output v_out, output busy);
endinterface

// File: rtl/rc_envelope_vcontrol_step.sv
// One exponential RC step: moves v toward VCC or ground by (span * K) >> 16,
// never stalling short of the rail and never crossing it.
module rc_exp_step
    import discrete_pkg::*;
(
    input  logic [15:0] v,
    input  logic        to_high,
    input  logic [15:0] k,
    output logic [15:0] v_next
);

    logic [15:0] span;
    logic [31:0] prod;
    logic [15:0] step;
    logic [16:0] sum;

    always_comb begin
        span = to_high ? (VCC_16 - v) : v;
        prod = 32'(span) * 32'(k);
        step = prod[31:16];
        if (step == '0 && span != '0) begin
            step = 16'd1;
        end
        sum = {1'b0, v} + {1'b0, step};
        if (to_high) begin
            v_next = sum[16] ? VCC_16 : sum[15:0];
        end else begin
            v_next = (step > v) ? '0 : (v - step);
        end
    end

endmodule

// File: rtl/rc_envelope_vcontrol.sv
// Charge/hold/discharge RC envelope producing the 555 VCO control voltage,
// updated once per audio sample strobe.
module rc_envelope_vcontrol
    import discrete_pkg::*;
#(
    parameter int unsigned CLOCK_RATE   = 50000000,
    parameter int unsigned SAMPLE_RATE  = 48000,
    parameter int unsigned R_CHARGE     = 10000,
    parameter int unsigned R_DISCHARGE  = 100000,
    parameter int unsigned C_35_SHIFTED = 343597,
    parameter int unsigned V_THRESHOLD  = 43690,
    parameter int unsigned HOLD_SAMPLES = 4800
) (
    input  logic                   clk,
    input  logic                   reset_n,
    rc_envelope_vcontrol_if.slave  env
);

    // Strobes cannot outpace the system clock, so the effective rate is capped there.
    localparam int unsigned FS = (SAMPLE_RATE <= CLOCK_RATE) ? SAMPLE_RATE : CLOCK_RATE;
    localparam logic [15:0] K_CH   = rc_coef_q16(R_CHARGE, C_35_SHIFTED, FS);
    localparam logic [15:0] K_DIS  = rc_coef_q16(R_DISCHARGE, C_35_SHIFTED, FS);
    localparam logic [15:0] V_TH   = 16'(V_THRESHOLD);
    localparam logic [15:0] HOLD_N = 16'(HOLD_SAMPLES);

    env_state_t  state, state_next;
    logic [15:0] v_q, v_next, v_step;
    logic [15:0] hold_cnt, hold_next;
    logic        trig_d, armed, busy_q;
    logic        trig_edge, use_charge;

    // armed blocks a trigger held high through reset from counting as an edge
    assign trig_edge  = env.trigger & ~trig_d & armed;
    assign use_charge = trig_edge | (state == CHARGE);

    rc_exp_step u_step (
        .v       (v_q),
        .to_high (use_charge),
        .k       (use_charge ? K_CH : K_DIS),
        .v_next  (v_step)
    );

    always_comb begin
        state_next = state;
        v_next     = v_q;
        hold_next  = hold_cnt;
        if (trig_edge || (env.audio_clk_en && state == CHARGE)) begin
            state_next = CHARGE;
            if (env.audio_clk_en) begin
                v_next = v_step;
                if (v_step >= V_TH) begin
                    state_next = HOLD;
                    hold_next  = HOLD_N;
                end
            end
        end else if (env.audio_clk_en) begin
            case (state)
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state_next = DISCHARGE;
                    end else begin
                        hold_next = hold_cnt - 16'd1;
                    end
                end
                DISCHARGE: begin
                    v_next = v_step;
                    if (v_step == '0) begin
                        state_next = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            v_q      <= '0;
            hold_cnt <= '0;
            trig_d   <= 1'b0;
            armed    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_next;
            v_q      <= v_next;
            hold_cnt <= hold_next;
            trig_d   <= env.trigger;
            armed    <= armed | ~env.trigger;
            busy_q   <= (state_next != IDLE);
        end
    end

    assign env.v_out = v_q;
    assign env.busy  = busy_q;

endmodule

// File: tb/tb_rc_envelope_vcontrol.sv
// Directed bench for rc_envelope_vcontrol with K_CH = 32768, K_DIS = 16384, HOLD = 3.
module tb_rc_envelope_vcontrol;
    import discrete_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rc_envelope_vcontrol_if env_if ();

    rc_envelope_vcontrol #(
        .SAMPLE_RATE  (1),
        .C_35_SHIFTED (1 << 20),
        .R_CHARGE     (1 << 16),
        .R_DISCHARGE  (1 << 17),
        .HOLD_SAMPLES (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .env     (env_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic en, input logic trig);
        @(negedge clk);
        env_if.audio_clk_en = en;
        env_if.trigger      = trig;
        @(posedge clk);
        #1;
        env_if.audio_clk_en = 1'b0;
    endtask

    task automatic check_state(input string tag, input env_state_t exp);
        check_eq(tag, 32'(dut.state), 32'(exp));
    endtask

    // Each discharge step removes v/4 (K_DIS = 1/4), at least 1, until 0.
    task automatic drain(input logic [15:0] start);
        logic [15:0] m;
        m = start;
        for (int i = 0; i < 300 && m != 0; i++) begin
            tick(1'b1, 1'b0);
            m = m - (((m >> 2) != 0) ? (m >> 2) : 16'd1);
            check_eq("discharge_v", 32'(env_if.v_out), 32'(m));
        end
        check_eq("drain_busy", 32'(env_if.busy), 32'd0);
        check_state("drain_state", IDLE);
    endtask

    // Edge, two charge strobes, then four HOLD strobes at 49151.
    task automatic charge_and_hold();
        tick(1'b0, 1'b1);
        check_eq("edge_busy", 32'(env_if.busy), 32'd1);
        check_eq("edge_v", 32'(env_if.v_out), 32'd0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check_eq("charge1_v", 32'(env_if.v_out), 32'd32767);
        check_state("charge1_state", CHARGE);
        tick(1'b1, 1'b0);
        check_eq("charge2_v", 32'(env_if.v_out), 32'd49151);
        check_state("charge2_state", HOLD);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            check_eq("hold_v", 32'(env_if.v_out), 32'd49151);
            check_eq("hold_busy", 32'(env_if.busy), 32'd1);
            check_state("hold_state", (i == 3) ? DISCHARGE : HOLD);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        env_if.audio_clk_en = 1'b0;
        env_if.trigger      = 1'b0;
        #12;
        check_eq("reset_v", 32'(env_if.v_out), 32'd0);
        check_eq("reset_busy", 32'(env_if.busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0);
            check_eq("idle_v", 32'(env_if.v_out), 32'd0);
            check_eq("idle_busy", 32'(env_if.busy), 32'd0);
        end

        // Envelope A: full cycle back to IDLE
        charge_and_hold();
        tick(1'b1, 1'b0);
        check_eq("dis1_v", 32'(env_if.v_out), 32'd36864);
        tick(1'b1, 1'b0);
        check_eq("dis2_v", 32'(env_if.v_out), 32'd27648);
        tick(1'b1, 1'b0);
        check_eq("dis3_v", 32'(env_if.v_out), 32'd20736);
        drain(16'd20736);
        tick(1'b1, 1'b0);
        check_eq("post_idle_v", 32'(env_if.v_out), 32'd0);

        // Envelope B: edge coincident with a HOLD strobe
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check_eq("b_charge_v", 32'(env_if.v_out), 32'd49151);
        tick(1'b1, 1'b0);
        check_state("b_hold_state", HOLD);
        tick(1'b1, 1'b1);
        check_eq("coincide_v", 32'(env_if.v_out), 32'd57343);
        check_state("coincide_state", HOLD);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            check_eq("b_hold_v", 32'(env_if.v_out), 32'd57343);
        end
        check_state("b_dis_state", DISCHARGE);
        drain(16'd57343);

        // Envelope C: retrigger during DISCHARGE
        charge_and_hold();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check_eq("c_dis_v", 32'(env_if.v_out), 32'd27648);
        tick(1'b0, 1'b1);
        check_state("retrig_state", CHARGE);
        check_eq("retrig_v", 32'(env_if.v_out), 32'd27648);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check_eq("retrig_step_v", 32'(env_if.v_out), 32'd46591);
        check_state("retrig_hold", HOLD);

        // Asynchronous reset mid-CHARGE, trigger held high across release
        tick(1'b0, 1'b1);
        check_state("pre_reset_state", CHARGE);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_v", 32'(env_if.v_out), 32'd0);
        check_eq("async_rst_busy", 32'(env_if.busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            check_eq("held_trig_busy", 32'(env_if.busy), 32'd0);
            check_eq("held_trig_v", 32'(env_if.v_out), 32'd0);
        end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check_eq("rearm_busy", 32'(env_if.busy), 32'd1);
        tick(1'b1, 1'b1);
        check_eq("rearm_v", 32'(env_if.v_out), 32'd32767);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
